// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl -- multi-cycle MIPS-subset control unit.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> [MEM] -> [WB]
// and drives the datapath strobes and selects. Illegal instructions and
// memory accesses that wait too long for mem_ready park the unit in HALT with
// a sticky fault until rst.
//
// Parameters
//   WAIT_MAX   maximum consecutive cycles an access may wait for mem_ready
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   opcode, funct    IR[31:26] / IR[5:0]
//   zero             ALU equality flag (used in EXEC)
//   mem_ready        memory completes the requested access this cycle
//   mem_req, mem_we  memory request / write qualifier
//   iord             memory address select: 0=PC, 1=ALUOut
//   ir_write         IR load strobe
//   pc_write         PC load strobe
//   pc_src           0=PC+4, 1=branch target, 2=jump target
//   reg_write        register-file write strobe
//   reg_dst          0=rt, 1=rd
//   mem2reg          register write data from MDR
//   alu_src          0=register, 1=extended immediate
//   ext_op           1=sign extend, 0=zero extend
//   fault            sticky illegal-instruction / memory-timeout flag
//   state            current state encoding
//   instr_cnt        retired-instruction counter (only with INSTR_CNT_EN)
//
// Build option
//   INSTR_CNT_EN     when defined, adds the 32-bit instr_cnt output.
// ---------------------------------------------------------------------------
module mc_ctrl #(
  parameter int WAIT_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem2reg,
  output logic       alu_src,
  output logic       ext_op,
  output logic       fault,
  output logic [2:0] state
`ifdef INSTR_CNT_EN
  , output logic [31:0] instr_cnt
`endif
);

  localparam int WCW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t           state_reg;
  logic             fault_reg;
  logic [WCW-1:0]   wait_reg;

  // Instruction classification straight from the IR fields; the IR is held
  // stable from the end of FETCH until the next FETCH completes.
  logic is_rtype, r_legal, is_imm, is_lw, is_sw, is_beq, is_bne, is_j;
  logic legal, uses_imm, is_ori, wait_expired;

  always_comb begin
    is_rtype = (opcode == OP_RTYPE);
    r_legal  = is_rtype && (funct inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h00,
                                          6'h02, 6'h2A, 6'h24, 6'h25});
    is_imm   = opcode inside {OP_SLTI, OP_ORI, OP_LUI};
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_beq   = (opcode == OP_BEQ);
    is_bne   = (opcode == OP_BNE);
    is_j     = (opcode == OP_J);
    is_ori   = (opcode == OP_ORI);
    legal    = r_legal | is_imm | is_lw | is_sw | is_beq | is_bne | is_j;
    uses_imm = is_imm | is_lw | is_sw;
    // The cycle that would bring the count to WAIT_MAX is the last one an
    // access may wait; mem_ready in that same cycle still wins.
    wait_expired = (wait_reg == WCW'(WAIT_MAX - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_FETCH;
      fault_reg <= 1'b0;
      wait_reg  <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (mem_ready) begin
            state_reg <= S_DECODE;
            wait_reg  <= '0;
          end else if (wait_expired) begin
            state_reg <= S_HALT;
            fault_reg <= 1'b1;
            wait_reg  <= '0;
          end else begin
            wait_reg <= wait_reg + WCW'(1);
          end
        end
        S_DECODE: begin
          if (legal) begin
            state_reg <= S_EXEC;
          end else begin
            state_reg <= S_HALT;
            fault_reg <= 1'b1;
          end
        end
        S_EXEC: begin
          if (is_lw || is_sw)
            state_reg <= S_MEM;
          else if (is_beq || is_bne || is_j)
            state_reg <= S_FETCH;
          else
            state_reg <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            state_reg <= is_sw ? S_FETCH : S_WB;
            wait_reg  <= '0;
          end else if (wait_expired) begin
            state_reg <= S_HALT;
            fault_reg <= 1'b1;
            wait_reg  <= '0;
          end else begin
            wait_reg <= wait_reg + WCW'(1);
          end
        end
        S_WB:    state_reg <= S_FETCH;
        S_HALT:  state_reg <= S_HALT;
        default: state_reg <= S_HALT;
      endcase
    end
  end

`ifdef INSTR_CNT_EN
  // An instruction retires on every return to FETCH from EXEC, MEM or WB.
  logic instr_done;
  always_comb begin
    instr_done = ((state_reg == S_EXEC) && (is_beq || is_bne || is_j)) ||
                 ((state_reg == S_MEM) && mem_ready && is_sw) ||
                 (state_reg == S_WB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      instr_cnt <= '0;
    else if (instr_done)
      instr_cnt <= instr_cnt + 32'd1;
  end
`endif

  assign state = state_reg;
  assign fault = fault_reg;

  // Strobes are decoded from the registered state; the FETCH/MEM completion
  // strobes follow mem_ready in the same cycle. rst gates everything to 0 so
  // an access in flight is abandoned without a PC/IR/RF write.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    mem2reg   = 1'b0;
    alu_src   = 1'b0;
    ext_op    = 1'b0;
    if (!rst) begin
      ext_op = !is_ori;
      case (state_reg)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC: begin
          alu_src = uses_imm;
          if (is_beq) begin
            pc_write = zero;
            pc_src   = 2'd1;
          end else if (is_bne) begin
            pc_write = !zero;
            pc_src   = 2'd1;
          end else if (is_j) begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = is_sw;
          alu_src = uses_imm;
        end
        S_WB: begin
          reg_write = 1'b1;
          reg_dst   = is_rtype;
          mem2reg   = is_lw;
          alu_src   = uses_imm;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl.
//
// Random instruction streams (random legal opcodes, random mem_ready wait
// lengths below the timeout, random zero) are compared each cycle against a
// reference model that derives the expected phase sequence of every
// instruction from its class and the expected outputs from a per-phase table.
// Directed tasks cover reset, illegal instructions, memory timeouts at the
// boundary, and reset during a store. Define INSTR_CNT_EN to also check the
// retired-instruction counter.
// ---------------------------------------------------------------------------
module tb_mc_ctrl;

  localparam int WAIT_MAX = 4;

  // Model phase numbers (the encoding the outputs must report).
  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_HALT = 7;
  // Instruction classes.
  localparam int K_RALU = 0, K_IMM = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5, K_J = 6, K_ILL = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_write, reg_dst, mem2reg, alu_src, ext_op, fault;
  logic [2:0] state;
`ifdef INSTR_CNT_EN
  logic [31:0] instr_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cnt_model = 0;

  mc_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem2reg(mem2reg),
    .alu_src(alu_src), .ext_op(ext_op), .fault(fault), .state(state)
`ifdef INSTR_CNT_EN
    , .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
                reg_dst, mem2reg, alu_src, ext_op, fault, state};

  // Legal instruction table {opcode, funct}.
  function automatic logic [11:0] legal_entry(input int i);
    case (i)
      0: return {6'h00, 6'h20};  1: return {6'h00, 6'h21};
      2: return {6'h00, 6'h22};  3: return {6'h00, 6'h23};
      4: return {6'h00, 6'h00};  5: return {6'h00, 6'h02};
      6: return {6'h00, 6'h2A};  7: return {6'h00, 6'h24};
      8: return {6'h00, 6'h25};  9: return {6'h04, 6'h00};
      10: return {6'h05, 6'h00}; 11: return {6'h0A, 6'h00};
      12: return {6'h0D, 6'h00}; 13: return {6'h0F, 6'h00};
      14: return {6'h23, 6'h00}; 15: return {6'h2B, 6'h00};
      default: return {6'h02, 6'h00};
    endcase
  endfunction

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h00, 6'h02, 6'h2A, 6'h24, 6'h25})
        return K_RALU;
      return K_ILL;
    end
    case (op)
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h0A, 6'h0D, 6'h0F: return K_IMM;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h02: return K_J;
      default: return K_ILL;
    endcase
  endfunction

  // Expected output vector for one cycle in a given phase.
  function automatic logic [15:0] expect_out(input int ph, input logic [5:0] op,
                                             input logic [5:0] fn, input logic z,
                                             input logic rdy, input logic flt);
    int k;
    logic e_req, e_we, e_iord, e_ir, e_pc, e_rw, e_rd, e_m2r, e_as, e_ext;
    logic [1:0] e_src;
    k = kind_of(op, fn);
    e_req = 0; e_we = 0; e_iord = 0; e_ir = 0; e_pc = 0; e_src = 2'd0;
    e_rw = 0; e_rd = 0; e_m2r = 0; e_as = 0;
    e_ext = (op != 6'h0D);
    case (ph)
      P_FETCH: begin e_req = 1; e_ir = rdy; e_pc = rdy; end
      P_EXEC: begin
        e_as = (k == K_IMM || k == K_LW || k == K_SW);
        if (k == K_BEQ) begin e_pc = z;  e_src = 2'd1; end
        if (k == K_BNE) begin e_pc = !z; e_src = 2'd1; end
        if (k == K_J)   begin e_pc = 1;  e_src = 2'd2; end
      end
      P_MEM: begin
        e_req = 1; e_iord = 1; e_we = (k == K_SW);
        e_as = (k == K_LW || k == K_SW);
      end
      P_WB: begin
        e_rw = 1; e_rd = (k == K_RALU); e_m2r = (k == K_LW);
        e_as = (k == K_IMM || k == K_LW);
      end
      default: ;
    endcase
    return {e_req, e_we, e_iord, e_ir, e_pc, e_src, e_rw, e_rd, e_m2r, e_as,
            e_ext, flt, 3'(ph)};
  endfunction

  // Reset pulse: all outputs 0 while rst is high. Starts and ends at posedge+1.
  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      opcode = 6'($urandom); funct = 6'($urandom);
      zero = 1'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
      vectors++;
      if (obs !== 16'h0) begin
        miscompares++;
        $display("FAIL reset_outputs got=%h want=0000", obs);
      end
`ifdef INSTR_CNT_EN
      vectors++;
      if (instr_cnt !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_instr_cnt got=%0d want=0", instr_cnt);
      end
`endif
      @(posedge clk); #1;
    end
    rst = 1'b0;
    cnt_model = 0;
  endtask

  // n instructions; fixed<0 picks random legal instructions, maxw bounds the
  // zero-ready cycles before each access, zsel<0 randomizes zero.
  task automatic test_program(input int n, input int fixed, input int maxw, input int zsel);
    for (int i = 0; i < n; i++) begin
      int ph_q[$];
      int rdy_q[$];
      int idx, fw, mw, k;
      logic [11:0] ent;
      logic z;
      idx = (fixed >= 0) ? fixed : int'($urandom_range(0, 16));
      ent = legal_entry(idx);
      k = kind_of(ent[11:6], ent[5:0]);
      fw = int'($urandom_range(0, maxw));
      mw = int'($urandom_range(0, maxw));
      z = (zsel >= 0) ? 1'(zsel) : 1'($urandom);
      for (int w = 0; w < fw; w++) begin ph_q.push_back(P_FETCH); rdy_q.push_back(0); end
      ph_q.push_back(P_FETCH); rdy_q.push_back(1);
      ph_q.push_back(P_DECODE); rdy_q.push_back(0);
      ph_q.push_back(P_EXEC); rdy_q.push_back(0);
      if (k == K_LW || k == K_SW) begin
        for (int w = 0; w < mw; w++) begin ph_q.push_back(P_MEM); rdy_q.push_back(0); end
        ph_q.push_back(P_MEM); rdy_q.push_back(1);
      end
      if (k == K_RALU || k == K_IMM || k == K_LW) begin
        ph_q.push_back(P_WB); rdy_q.push_back(0);
      end
      for (int s = 0; s < ph_q.size(); s++) begin
        logic [15:0] want;
        opcode = ent[11:6]; funct = ent[5:0];
        zero = (ph_q[s] == P_EXEC) ? z : 1'($urandom);
        // Outside FETCH/MEM mem_ready is random noise that must be ignored.
        mem_ready = (ph_q[s] == P_FETCH || ph_q[s] == P_MEM) ? 1'(rdy_q[s]) : 1'($urandom);
        @(negedge clk);
        want = expect_out(ph_q[s], opcode, funct, zero, mem_ready, 1'b0);
        vectors++;
        if (obs !== want) begin
          miscompares++;
          $display("FAIL program op=%h fn=%h step=%0d got=%h want=%h",
                   opcode, funct, s, obs, want);
        end
`ifdef INSTR_CNT_EN
        if (s == 0) begin
          vectors++;
          if (instr_cnt !== 32'(cnt_model)) begin
            miscompares++;
            $display("FAIL instr_cnt got=%0d want=%0d", instr_cnt, cnt_model);
          end
        end
`endif
        @(posedge clk); #1;
      end
      cnt_model++;
    end
  endtask

  task automatic test_alu();      test_program(4, 0, 0, -1); test_program(6, -1, 0, -1); endtask
  task automatic test_lw_sw();    test_program(3, 14, 0, -1); test_program(3, 15, 3, -1); endtask
  task automatic test_branch();
    test_program(1, 9, 0, 1);  test_program(1, 9, 0, 0);
    test_program(1, 10, 0, 1); test_program(1, 10, 0, 0);
    test_program(2, 16, 1, -1);
  endtask
  task automatic test_random();   test_program(60, -1, WAIT_MAX - 1, -1); endtask

  // Illegal opcode or R-type funct: DECODE, then HALT with fault until rst.
  task automatic test_illegal(input int which);
    logic [5:0] op, fn;
    logic [15:0] want;
    if (which == 0) begin
      op = 6'h3F; fn = 6'($urandom);
    end else begin
      op = 6'h00;
      do fn = 6'($urandom); while (kind_of(op, fn) != K_ILL);
    end
    opcode = op; funct = fn; mem_ready = 1'b1; zero = 1'($urandom);
    @(negedge clk);
    want = expect_out(P_FETCH, op, fn, zero, 1'b1, 1'b0);
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL illegal_fetch got=%h want=%h", obs, want);
    end
    @(posedge clk); #1;
    mem_ready = 1'($urandom);
    @(negedge clk);
    want = expect_out(P_DECODE, op, fn, zero, mem_ready, 1'b0);
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL illegal_decode got=%h want=%h", obs, want);
    end
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      mem_ready = 1'($urandom); zero = 1'($urandom);
      @(negedge clk);
      want = expect_out(P_HALT, op, fn, zero, mem_ready, 1'b1);
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL illegal_halt cyc=%0d got=%h want=%h", c, obs, want);
      end
      @(posedge clk); #1;
    end
    test_reset();
  endtask

  // WAIT_MAX cycles waiting in FETCH or MEM; ready_last delivers mem_ready in
  // the last allowed cycle, otherwise the unit must halt with fault.
  task automatic test_timeout(input bit in_mem, input bit ready_last);
    logic [5:0] op;
    logic [15:0] want;
    int wait_ph, next_ph;
    op = ready_last ? 6'h23 : (($urandom % 2) ? 6'h23 : 6'h2B);
    opcode = op; funct = 6'h00; zero = 1'b0;
    if (in_mem) begin
      for (int p = 0; p < 3; p++) begin
        mem_ready = (p == 0);
        @(negedge clk);
        want = expect_out(p, op, 6'h00, 1'b0, mem_ready, 1'b0);
        vectors++;
        if (obs !== want) begin
          miscompares++;
          $display("FAIL timeout_lead ph=%0d got=%h want=%h", p, obs, want);
        end
        @(posedge clk); #1;
      end
    end
    wait_ph = in_mem ? P_MEM : P_FETCH;
    for (int c = 0; c < WAIT_MAX; c++) begin
      mem_ready = (c == WAIT_MAX - 1) && ready_last;
      @(negedge clk);
      want = expect_out(wait_ph, op, 6'h00, 1'b0, mem_ready, 1'b0);
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL timeout_wait mem=%0d cyc=%0d got=%h want=%h", in_mem, c, obs, want);
      end
      @(posedge clk); #1;
    end
    next_ph = !ready_last ? P_HALT : (in_mem ? P_WB : P_DECODE);
    for (int c = 0; c < (ready_last ? 1 : 3); c++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      want = expect_out(next_ph, op, 6'h00, 1'b0, mem_ready, !ready_last);
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL timeout_after mem=%0d rdy=%0d got=%h want=%h", in_mem, ready_last, obs, want);
      end
      @(posedge clk); #1;
    end
    test_reset();
  endtask

  // rst raised while a SW is in MEM: outputs drop at once, FETCH afterwards.
  task automatic test_rst_mid_access();
    logic [15:0] want;
    opcode = 6'h2B; funct = 6'h00; zero = 1'b0;
    for (int p = 0; p < 4; p++) begin
      mem_ready = (p == 0);
      @(negedge clk);
      want = expect_out(p, 6'h2B, 6'h00, 1'b0, mem_ready, 1'b0);
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL rst_mid_lead ph=%0d got=%h want=%h", p, obs, want);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    vectors++;
    if (obs !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_mid_immediate got=%h want=0000", obs);
    end
    @(negedge clk);
    vectors++;
    if (obs !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_mid_held got=%h want=0000", obs);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    want = expect_out(P_FETCH, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL rst_mid_release got=%h want=%h", obs, want);
    end
`ifdef INSTR_CNT_EN
    vectors++;
    if (instr_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_mid_instr_cnt got=%0d want=0", instr_cnt);
    end
`endif
    @(posedge clk); #1;
    test_reset();
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_lw_sw();
    test_branch();
    test_rst_mid_access();
    test_random();
    test_illegal(0);
    test_illegal(1);
    test_timeout(1'b1, 1'b0);
    test_timeout(1'b1, 1'b1);
    test_timeout(1'b0, 1'b0);
    test_timeout(1'b0, 1'b1);
    test_program(10, -1, WAIT_MAX - 1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 WAIT_MAX, 4, maximum consecutive cycles a memory access may wait for mem_ready before fault.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  IR[31:26].
REQ-005 funct  input  6  IR[5:0].
REQ-006 zero  input  1  ALU equality flag, valid in EXEC.
REQ-007 mem_ready  input  1  memory completes the requested access this cycle.
REQ-008 mem_req / mem_we  output  1 / 1  memory request / write qualifier.
REQ-009 iord  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-010 ir_write / pc_write  output  1 / 1  IR load strobe / PC load strobe.
REQ-011 pc_src  output  2  0=PC+4, 1=branch target, 2=jump target.
REQ-012 reg_write / reg_dst / mem2reg  output  1 / 1 / 1  RF write strobe / 0=rt, 1=rd / write data from MDR.
REQ-013 alu_src / ext_op  output  1 / 1  0=reg, 1=extended imm / 1=sign, 0=zero extend.
REQ-014 fault  output  1  sticky: illegal instruction or memory timeout.
REQ-015 state  output  3  current state encoding.

Function
REQ-016 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7; other encodings SHALL go to HALT.
REQ-017 Legal set: R-type (opcode 0x00) with funct ADD 0x20, ADDU 0x21, SUB 0x22, SUBU 0x23, SLL 0x00, SRL 0x02, SLT 0x2A, AND 0x24, OR 0x25; BEQ 0x04, BNE 0x05, SLTI 0x0A, ORI 0x0D, LUI 0x0F, LW 0x23, SW 0x2B, J 0x02.
REQ-018 FETCH: mem_req=1, iord=0. On mem_ready: ir_write=1, pc_write=1, pc_src=0, then DECODE. Otherwise remain in FETCH.
REQ-019 DECODE: one cycle. Legal instruction -> EXEC. Illegal instruction -> HALT and set fault.
REQ-020 EXEC (ALU ops, SLTI, ORI, LUI) -> WB. LW/SW -> MEM.
REQ-021 EXEC BEQ: pc_write=zero, pc_src=1. EXEC BNE: pc_write=!zero, pc_src=1. EXEC J: pc_write=1, pc_src=2. All three -> FETCH.
REQ-022 MEM: mem_req=1, iord=1, mem_we=1 only for SW. On mem_ready: SW -> FETCH, LW -> WB.
REQ-023 WB: reg_write=1 for exactly one cycle, then FETCH. reg_dst=1 only for R-type. mem2reg=1 only for LW.
REQ-024 alu_src=1 for SLTI, ORI, LUI, LW, SW in EXEC/MEM/WB; 0 otherwise.
REQ-025 ext_op=0 for ORI, 1 otherwise.
REQ-026 All strobes (ir_write, pc_write, reg_write, mem_req, mem_we) SHALL be 0 outside the states listed above.
REQ-027 Wait counter: increments each FETCH/MEM cycle with mem_ready=0 and clears on mem_ready or state change. At WAIT_MAX -> HALT, fault=1. mem_ready arriving on the same cycle as the counter reaches WAIT_MAX SHALL complete the access without fault.
REQ-028 mem_ready while mem_req=0 SHALL be ignored.
REQ-029 HALT: all strobes 0; exit only via rst.

Reset
REQ-030 rst SHALL asynchronously set state=FETCH, fault=0, wait counter=0.
REQ-031 While rst is high, all strobe outputs SHALL be forced to 0, pc_src=0, and remaining outputs 0. The first mem_req SHALL assert in the first cycle after rst deasserts.
REQ-032 rst asserted mid-access SHALL abandon the access with no PC/IR/RF write.

Configuration
REQ-033 INSTR_CNT_EN defined: add output instr_cnt (32 bits), reset 0, incremented on every transition into FETCH from EXEC, MEM or WB, wrapping 0xFFFFFFFF -> 0.
REQ-034 INSTR_CNT_EN undefined: port and counter are absent; all other behaviour is identical.

Verification
REQ-035 ADD, mem_ready=1 in FETCH -> states 0,1,2,4,0. reg_write=1, reg_dst=1 in cycle 4 only.
REQ-036 LW, mem_ready=1 always -> states 0,1,2,3,4. iord=1 in MEM; mem2reg=1, reg_dst=0 in WB.
REQ-037 BEQ with zero=1 then zero=0 -> pc_write=1/pc_src=1 in the first EXEC, pc_write=0 in the second. BNE inverse.
REQ-038 Opcode 0x3F -> DECODE then HALT, fault=1, no further strobes until rst.
REQ-039 mem_ready held 0 for WAIT_MAX=4 cycles in MEM -> HALT, fault=1. With mem_ready on the 4th cycle -> completes, no fault.
REQ-040 rst pulsed during MEM of SW -> mem_we=0 immediately, state=FETCH, instr_cnt=0 (INSTR_CNT_EN).
